// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder.
// The request struct is sized for the widest supported configuration.
package mem_if_pkg;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);
  localparam int REQ_IDX_W   = 32;
  localparam int REQ_DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_IDX_W-1:0]  idx;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read.
// The read register only loads on reads, so writes leave the last read data in place.
module mem_array #(
  parameter int addr_bits = 10,
  parameter int width     = 32
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [addr_bits-1:0] idx,
  input  logic [width-1:0]     wdata,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem [2**addr_bits];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Backing-store responder: accepts one word request, waits a fixed latency,
// commits the access to the array and pulses a one-cycle response.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int addr_bits = 10,
  parameter int width     = 32,
  parameter int latency   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [width-1:0] req_addr_i,
  input  logic [width-1:0] req_wdata_i,
  output logic             resp_valid_o,
  output logic             resp_we_o,
  output logic [width-1:0] resp_rdata_o
);

  if (latency < 1 || latency > LATENCY_MAX) begin : g_bad_latency
    $error("data_mem_responder: latency must be in 1..%0d", LATENCY_MAX);
  end
  if (width > REQ_DATA_W || addr_bits + 2 > width) begin : g_bad_width
    $error("data_mem_responder: unsupported width/addr_bits combination");
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  mem_req_t         req_reg, req_next;
  logic             rd_seen_reg, rd_seen_next;
  logic             mem_en;
  logic [width-1:0] ram_rdata;
  logic             unused_bits;

  // Only the word index is meaningful; the rest of the address is dropped.
  assign unused_bits = ^{req_addr_i, req_reg};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      req_reg     <= '0;
      rd_seen_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      req_reg     <= req_next;
      rd_seen_reg <= rd_seen_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_next     = req_reg;
    rd_seen_next = rd_seen_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_next.we    = req_we_i;
          req_next.idx   = REQ_IDX_W'(req_addr_i[addr_bits+1:2]);
          req_next.wdata = REQ_DATA_W'(req_wdata_i);
          cnt_next       = CNT_W'(latency - 1);
          state_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
          if (!req_reg.we) begin
            rd_seen_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_we_o    = 1'b0;
    mem_en       = 1'b0;
    unique case (state_reg)
      ST_IDLE: req_ready_o = 1'b1;
      ST_WAIT: mem_en = (cnt_reg == '0);
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_we_o    = req_reg.we;
      end
      default: ;
    endcase
  end

  // The RAM output register is not reset; mask it until a read has committed since reset.
  assign resp_rdata_o = rd_seen_reg ? ram_rdata : '0;

  mem_array #(
    .addr_bits(addr_bits),
    .width    (width)
  ) u_mem (
    .clk  (clk_i),
    .en   (mem_en),
    .we   (req_reg.we),
    .idx  (req_reg.idx[addr_bits-1:0]),
    .wdata(req_reg.wdata[width-1:0]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: latency-3 instance for function/reset tests, latency-1 and
// latency-15 instances for response timing and back-to-back spacing.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        valid3, we3, ready3, rvalid3, rwe3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        valid_s, we_s;
  logic [31:0] addr_s, wdata_s;
  logic        ready1, rvalid1, rwe1;
  logic [31:0] rdata1;
  logic        ready15, rvalid15, rwe15;
  logic [31:0] rdata15;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.addr_bits(10), .width(32), .latency(3)) u3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid3), .req_ready_o(ready3),
    .req_we_i(we3), .req_addr_i(addr3), .req_wdata_i(wdata3),
    .resp_valid_o(rvalid3), .resp_we_o(rwe3), .resp_rdata_o(rdata3)
  );

  data_mem_responder #(.addr_bits(10), .width(32), .latency(1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_s), .req_ready_o(ready1),
    .req_we_i(we_s), .req_addr_i(addr_s), .req_wdata_i(wdata_s),
    .resp_valid_o(rvalid1), .resp_we_o(rwe1), .resp_rdata_o(rdata1)
  );

  data_mem_responder #(.addr_bits(10), .width(32), .latency(15)) u15 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_s), .req_ready_o(ready15),
    .req_we_i(we_s), .req_addr_i(addr_s), .req_wdata_i(wdata_s),
    .resp_valid_o(rvalid15), .resp_we_o(rwe15), .resp_rdata_o(rdata15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One latency-3 transaction: E0, two busy edges, response pulse, back to idle.
  task automatic xact3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic scramble, input string tag);
    check({tag, "_ready_pre"}, 32'(ready3), 32'd1);
    we3    = we;
    addr3  = addr;
    wdata3 = wdata;
    valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    if (scramble) begin
      addr3  = 32'h0000_0040;
      wdata3 = 32'h9999_9999;
      we3    = 1'b1;
    end
    for (int e = 1; e < 3; e++) begin
      tick();
      check({tag, "_busy"}, {30'd0, ready3, rvalid3}, 32'd0);
    end
    tick();
    check({tag, "_resp_valid"}, 32'(rvalid3), 32'd1);
    check({tag, "_resp_ready"}, 32'(ready3), 32'd0);
    check({tag, "_resp_we"}, 32'(rwe3), 32'(we));
    check({tag, "_rdata"}, rdata3, exp_rd);
    tick();
    check({tag, "_after"}, {30'd0, ready3, rvalid3}, 32'd2);
    $display("xact %s we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h", tag, we, addr, wdata, rdata3);
  endtask

  int pulses;
  int first1, second1, count1;
  int first15, second15, count15;

  initial begin
    rst     = 1'b1;
    valid3  = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
    valid_s = 1'b0; we_s = 1'b1; addr_s = 32'h20; wdata_s = 32'h5;
    #1;
    check("reset_ready", 32'(ready3), 32'd1);
    check("reset_valid", 32'(rvalid3), 32'd0);
    check("reset_we", 32'(rwe3), 32'd0);
    check("reset_rdata", rdata3, 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();

    xact3(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "wr40");
    xact3(1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd40");
    xact3(1'b1, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, "wr1000");
    xact3(1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0, "rd0");
    xact3(1'b0, 32'h0000_0003, 32'h0,         32'h1234_5678, 1'b0, "rd3");
    xact3(1'b1, 32'h0000_0080, 32'h0000_0000, 32'h1234_5678, 1'b0, "preload80");

    // Write interrupted by asynchronous reset before its commit edge.
    we3 = 1'b1; addr3 = 32'h0000_0080; wdata3 = 32'hAAAA_5555; valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    check("midrst_busy", 32'(ready3), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready3), 32'd1);
    check("midrst_valid", 32'(rvalid3), 32'd0);
    check("midrst_rdata", rdata3, 32'd0);
    tick();
    #3 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rvalid3) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    $display("xact midrst we=1 addr=0x00000080 wdata=0xaaaa5555 dropped");

    xact3(1'b0, 32'h0000_0080, 32'h0,         32'h0000_0000, 1'b0, "rd80");
    xact3(1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd40b");
    xact3(1'b1, 32'h0000_0100, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1, "wr100_scr");
    xact3(1'b0, 32'h0000_0100, 32'h0,         32'h1111_2222, 1'b0, "rd100");
    xact3(1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd40c");

    // Unknown request fields while idle and not valid must not start anything.
    we3 = 1'bx; addr3 = 'x; wdata3 = 'x;
    for (int c = 0; c < 3; c++) tick();
    check("xidle", {30'd0, ready3, rvalid3}, 32'd2);
    $display("xact xidle valid=0 ready=%0d", ready3);

    // Latency sweep with the request held valid continuously.
    first1 = -1; second1 = -1; count1 = 0;
    first15 = -1; second15 = -1; count15 = 0;
    valid_s = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      if (rvalid1) begin
        if (count1 == 0) first1 = k;
        else if (count1 == 1) second1 = k;
        count1++;
      end
      if (rvalid15) begin
        if (count15 == 0) first15 = k;
        else if (count15 == 1) second15 = k;
        count15++;
      end
    end
    valid_s = 1'b0;
    check("lat1_first", 32'(first1), 32'd1);
    check("lat1_gap", 32'(second1 - first1), 32'd3);
    check("lat1_count", 32'(count1), 32'd17);
    check("lat15_first", 32'(first15), 32'd15);
    check("lat15_gap", 32'(second15 - first15), 32'd17);
    check("lat15_count", 32'(count15), 32'd3);
    $display("xact sweep lat1 first=%0d gap=%0d lat15 first=%0d gap=%0d",
             first1, second1 - first1, first15, second15 - first15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
